// File: rtl/bus_pkg.sv
// Shared definitions for the bus stages: default word width and the
// serializer state encoding.
package bus_pkg;

  localparam int BUS_WIDTH = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } bus_state_e;

endpackage

// File: rtl/bus_parity.sv
// Even-parity reduction: output is 1 when the word holds an odd number of ones,
// so that word plus parity bit always carries an even count.
module bus_parity #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] data_i,
  output logic             parity_o
);

  assign parity_o = ^data_i;

endmodule

// File: rtl/bus_serializer.sv
// Parallel-to-serial converter: accepts a WIDTH-bit word, shifts it out one bit
// per cycle in the selected order, optionally followed by an even-parity bit.
module bus_serializer
  import bus_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             msb_first,
  input  logic             par_en,
  input  logic             load,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  bus_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             par_q, par_d;
  logic             sout_q, sout_d;
  logic             valid_q, valid_d;
  logic             start_q, start_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] ordered;
  logic             parity;

  // The word is stored already reordered so that bit 0 is always sent first;
  // parity does not depend on bit order, so the reorder is harmless there.
  assign ordered = msb_first ? {<<{din}} : din;

  bus_parity #(.WIDTH(WIDTH)) u_parity (
    .data_i   (data_q),
    .parity_o (parity)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      sout_q  <= 1'b0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      par_q   <= par_d;
      sout_q  <= sout_d;
      valid_q <= valid_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end

  // Outputs are computed one cycle ahead so every frame bit leaves a register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    par_d   = par_q;
    sout_d  = 1'b0;
    valid_d = 1'b0;
    start_d = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (load) begin
          data_d  = ordered;
          par_d   = par_en;
          cnt_d   = '0;
          sout_d  = ordered[0];
          valid_d = 1'b1;
          start_d = 1'b1;
          done_d  = (WIDTH == 1) && !par_en;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (par_q) begin
            state_d = PARITY;
            sout_d  = parity;
            valid_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d   = cnt_q + CW'(1);
          sout_d  = data_q[cnt_d];
          valid_d = 1'b1;
          done_d  = (cnt_d == LAST) && !par_q;
        end
      end
      PARITY: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ready       = (state_q == IDLE);
  assign sout        = sout_q;
  assign sout_valid  = valid_q;
  assign frame_start = start_q;
  assign done        = done_q;

endmodule

// File: tb/tb_bus_serializer.sv
// Self-checking bench for bus_serializer: directed frames plus randomized
// frames compared against an expected-bit-list model built from the word.
module tb_bus_serializer;

  logic       clk;
  logic       reset;
  logic [5:0] din;
  logic       msb_first;
  logic       par_en;
  logic       load;
  logic       ready;
  logic       sout;
  logic       sout_valid;
  logic       frame_start;
  logic       done;

  int total = 0;
  int bad   = 0;

  bus_serializer #(.WIDTH(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .msb_first   (msb_first),
    .par_en      (par_en),
    .load        (load),
    .ready       (ready),
    .sout        (sout),
    .sout_valid  (sout_valid),
    .frame_start (frame_start),
    .done        (done)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one full cycle; inputs change and outputs are sampled at negedge.
  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [5:0] d, input logic m,
                               input logic p, input logic l);
    din       = d;
    msb_first = m;
    par_en    = p;
    load      = l;
  endtask

  task automatic checkOutput(input string tag, input logic observed,
                             input logic expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Idle cycle: ready high and no frame activity on any output.
  task automatic checkIdle(input string tag);
    checkOutput({tag, "_ready"}, ready, 1'b1);
    checkOutput({tag, "_valid"}, sout_valid, 1'b0);
    checkOutput({tag, "_sout"}, sout, 1'b0);
    checkOutput({tag, "_start"}, frame_start, 1'b0);
    checkOutput({tag, "_done"}, done, 1'b0);
  endtask

  // Expected frame: the word's bits in the requested order, then the even
  // parity bit when enabled. Called at the negedge of the first frame cycle;
  // returns at the negedge of the cycle after done.
  task automatic checkFrame(input logic [5:0] d, input logic m, input logic p,
                            input bit scramble, input string tag);
    logic expBits[$];
    logic [5:0] w;
    w = d;
    expBits = {};
    for (int i = 0; i < 6; i++)
      expBits.push_back(m ? w[5-i] : w[i]);
    if (p)
      expBits.push_back(($countones(w) % 2) == 1);
    for (int k = 0; k < expBits.size(); k++) begin
      checkOutput($sformatf("%s_valid%0d", tag, k), sout_valid, 1'b1);
      checkOutput($sformatf("%s_bit%0d", tag, k), sout, expBits[k]);
      checkOutput($sformatf("%s_start%0d", tag, k), frame_start, k == 0);
      checkOutput($sformatf("%s_done%0d", tag, k), done, k == expBits.size() - 1);
      checkOutput($sformatf("%s_busy%0d", tag, k), ready, 1'b0);
      if (scramble)
        applyStimulus(6'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      stepCycle();
    end
    checkOutput({tag, "_readyAfter"}, ready, 1'b1);
    checkOutput({tag, "_gapValid"}, sout_valid, 1'b0);
  endtask

  logic [5:0] rd;
  logic       rm, rp;
  int         gap;

  initial begin
    applyStimulus(6'd0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    stepCycle();
    stepCycle();
    checkIdle("reset");
    reset = 1'b0;
    applyStimulus(6'd0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    checkIdle("postReset");

    // MSB first, no parity.
    applyStimulus(6'b110010, 1'b1, 1'b0, 1'b1);
    stepCycle();
    applyStimulus(6'b001101, 1'b0, 1'b1, 1'b0);
    checkFrame(6'b110010, 1'b1, 1'b0, 1'b0, "msbNoPar");
    checkIdle("msbNoParIdle");

    // LSB first with parity.
    applyStimulus(6'b110010, 1'b0, 1'b1, 1'b1);
    stepCycle();
    applyStimulus(6'b000000, 1'b1, 1'b0, 1'b0);
    checkFrame(6'b110010, 1'b0, 1'b1, 1'b0, "lsbPar");

    // Load held high and din changed mid-frame; next word waits for ready.
    applyStimulus(6'b000111, 1'b1, 1'b1, 1'b1);
    stepCycle();
    applyStimulus(6'b111111, 1'b1, 1'b1, 1'b1);
    checkFrame(6'b000111, 1'b1, 1'b1, 1'b0, "holdLoad");
    stepCycle();
    applyStimulus(6'b000000, 1'b0, 1'b0, 1'b0);
    checkFrame(6'b111111, 1'b1, 1'b1, 1'b0, "holdLoad2");

    // Reset in the third frame cycle, with load asserted alongside it.
    applyStimulus(6'b101101, 1'b1, 1'b1, 1'b1);
    stepCycle();
    applyStimulus(6'b101101, 1'b1, 1'b1, 1'b0);
    checkOutput("abort_c1", sout, 1'b1);
    stepCycle();
    checkOutput("abort_c2", sout, 1'b0);
    stepCycle();
    checkOutput("abort_c3", sout, 1'b1);
    reset = 1'b1;
    load  = 1'b1;
    stepCycle();
    checkIdle("abortReset");
    reset = 1'b0;
    load  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      stepCycle();
      checkOutput($sformatf("abortQuiet_done%0d", i), done, 1'b0);
      checkOutput($sformatf("abortQuiet_valid%0d", i), sout_valid, 1'b0);
    end
    applyStimulus(6'b011001, 1'b0, 1'b1, 1'b1);
    stepCycle();
    applyStimulus(6'b000000, 1'b0, 1'b0, 1'b0);
    checkFrame(6'b011001, 1'b0, 1'b1, 1'b0, "afterAbort");

    // Back-to-back loads held continuously: exactly one idle cycle between.
    applyStimulus(6'b101010, 1'b1, 1'b0, 1'b1);
    stepCycle();
    applyStimulus(6'b010101, 1'b1, 1'b0, 1'b1);
    checkFrame(6'b101010, 1'b1, 1'b0, 1'b0, "b2bA");
    stepCycle();
    applyStimulus(6'b000000, 1'b0, 1'b0, 1'b0);
    checkFrame(6'b010101, 1'b1, 1'b0, 1'b0, "b2bB");

    // Parity corner words.
    applyStimulus(6'b000000, 1'b1, 1'b1, 1'b1);
    stepCycle();
    applyStimulus(6'b111110, 1'b0, 1'b0, 1'b0);
    checkFrame(6'b000000, 1'b1, 1'b1, 1'b0, "parZero");
    applyStimulus(6'b000001, 1'b1, 1'b1, 1'b1);
    stepCycle();
    applyStimulus(6'b000000, 1'b0, 1'b0, 1'b0);
    checkFrame(6'b000001, 1'b1, 1'b1, 1'b0, "parOne");

    // Random frames with inputs scrambled (including stray loads) mid-frame.
    for (int n = 0; n < 40; n++) begin
      rd = 6'($urandom);
      rm = 1'($urandom);
      rp = 1'($urandom);
      applyStimulus(rd, rm, rp, 1'b1);
      stepCycle();
      checkFrame(rd, rm, rp, 1'b1, $sformatf("rand%0d", n));
      load = 1'b0;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        stepCycle();
        checkIdle($sformatf("rand%0d_gap%0d", n, g));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
